// File: rtl/mem_ctr.sv
// Data-memory controller for the pipeline memory stage: one load/store at a time
// against a word-organised RAM, with programmable wait states and byte-lane masking.
module mem_ctr #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req,
  input  logic        i_op,
  input  logic [2:0]  i_func_3,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_rdata,
  output logic        o_done,
  output logic        o_busy,
  output logic        o_fault
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, WAIT, ACCESS, RESP} state_t;

  state_t         state_q;
  logic [3:0]     cnt_q;
  logic           op_q;
  logic [1:0]     size_q;
  logic [AW+1:0]  addr_q;
  logic [31:0]    wdata_q;

  logic [31:0]    mem [DEPTH_WORDS];
  logic [AW-1:0]  idx;
  logic [31:0]    word;
  logic [31:0]    load_data;
  logic [31:0]    wr_data;
  logic [3:0]     be;
  logic           req_fault;
  logic           addr_unused;

  // Address bits above the RAM index are dropped so accesses wrap modulo the RAM size.
  assign addr_unused = |i_addr[31:AW+2];
  assign idx         = addr_q[AW+1:2];
  assign word        = mem[idx];

  assign o_busy = (state_q == IDLE && i_req) || state_q == WAIT || state_q == ACCESS;

  always_comb begin
    req_fault = 1'b0;
    case (i_func_3)
      3'd0:    req_fault = 1'b0;
      3'd1:    req_fault = i_addr[0];
      3'd2:    req_fault = |i_addr[1:0];
      3'd4:    req_fault = i_op;
      3'd5:    req_fault = i_op | i_addr[0];
      default: req_fault = 1'b1;
    endcase
  end

  // funct3[2] only selects zero-extension, which is the only load behaviour here.
  always_comb begin
    load_data = '0;
    wr_data   = '0;
    be        = '0;
    case (size_q)
      2'd0: begin
        load_data = {24'b0, word[{addr_q[1:0], 3'b000} +: 8]};
        wr_data   = {4{wdata_q[7:0]}};
        be        = 4'b0001 << addr_q[1:0];
      end
      2'd1: begin
        load_data = {16'b0, word[{addr_q[1], 4'b0000} +: 16]};
        wr_data   = {2{wdata_q[15:0]}};
        be        = addr_q[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        load_data = word;
        wr_data   = wdata_q;
        be        = 4'b1111;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (state_q == ACCESS && op_q) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= 1'b0;
      size_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      o_rdata <= '0;
      o_done  <= 1'b0;
      o_fault <= 1'b0;
    end else begin
      o_done  <= 1'b0;
      o_fault <= 1'b0;
      case (state_q)
        IDLE: begin
          if (i_req) begin
            op_q    <= i_op;
            size_q  <= i_func_3[1:0];
            addr_q  <= i_addr[AW+1:0];
            wdata_q <= i_wdata;
            if (req_fault) begin
              o_rdata <= '0;
              o_done  <= 1'b1;
              o_fault <= 1'b1;
              state_q <= RESP;
            end else if (WAIT_STATES == 0) begin
              state_q <= ACCESS;
            end else begin
              cnt_q   <= WAIT_STATES[3:0];
              state_q <= WAIT;
            end
          end
        end
        WAIT: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) state_q <= ACCESS;
        end
        ACCESS: begin
          o_rdata <= op_q ? '0 : load_data;
          o_done  <= 1'b1;
          state_q <= RESP;
        end
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ctr.sv
// Self-checking bench for mem_ctr: one instance with two wait states, one with none.
module tb_mem_ctr;

  localparam int unsigned DEPTH = 1024;
  localparam int unsigned WS_A  = 2;
  localparam logic LD = 1'b0;
  localparam logic ST = 1'b1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b1;
  logic        req_a = 1'b0, op_a = 1'b0;
  logic [2:0]  f3_a = '0;
  logic [31:0] addr_a = '0, wdata_a = '0, rdata_a;
  logic        done_a, busy_a, fault_a;
  logic        req_b = 1'b0, op_b = 1'b0;
  logic [2:0]  f3_b = '0;
  logic [31:0] addr_b = '0, wdata_b = '0, rdata_b;
  logic        done_b, busy_b, fault_b;

  mem_ctr #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(WS_A)) dut_a (
    .clk(clk), .rst_n(rst_n), .i_req(req_a), .i_op(op_a), .i_func_3(f3_a),
    .i_addr(addr_a), .i_wdata(wdata_a), .o_rdata(rdata_a), .o_done(done_a),
    .o_busy(busy_a), .o_fault(fault_a)
  );

  mem_ctr #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .i_req(req_b), .i_op(op_b), .i_func_3(f3_b),
    .i_addr(addr_b), .i_wdata(wdata_b), .o_rdata(rdata_b), .o_done(done_b),
    .o_busy(busy_b), .o_fault(fault_b)
  );

  typedef struct {
    logic        op;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        fault;
  } req_t;

  typedef struct {
    logic [31:0] rdata;
    logic        fault;
    int unsigned lat;
  } exp_t;

  typedef struct {
    logic [31:0] rdata;
    logic        fault;
    int unsigned lat;
    logic        busy_gap;
    logic        busy_resp;
  } obs_t;

  exp_t        exp_q[$];
  obs_t        obs_q[$];
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  function automatic exp_t expect_of(input req_t r, input int unsigned ws);
    exp_t e;
    e.rdata = r.fault ? 32'h0 : r.rdata;
    e.fault = r.fault;
    e.lat   = r.fault ? 1 : ws + 2;
    return e;
  endfunction

  // Drives one request on dut_a starting just after a rising edge and records what comes back.
  task automatic run_req(input req_t r);
    obs_t o;
    bit   got;
    o.rdata = 32'hx; o.fault = 1'bx; o.lat = 999; o.busy_gap = 1'b0; o.busy_resp = 1'b0;
    got = 1'b0;
    op_a = r.op; f3_a = r.f3; addr_a = r.addr; wdata_a = r.wdata; req_a = 1'b1;
    for (int unsigned c = 0; c < 40 && !got; c++) begin
      @(negedge clk);
      if (done_a) begin
        got = 1'b1; o.lat = c; o.rdata = rdata_a; o.fault = fault_a; o.busy_resp = busy_a;
        req_a = 1'b0;
      end else if (!busy_a) begin
        o.busy_gap = 1'b1;
      end
      @(posedge clk); #1;
    end
    req_a = 1'b0;
    obs_q.push_back(o);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    @(negedge clk);
    n_checks++; if (rdata_a !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h, expected 0", rdata_a); end
    n_checks++; if (done_a !== 1'b0)   begin n_fail++; $display("FAIL reset_done: got %b, expected 0", done_a); end
    n_checks++; if (fault_a !== 1'b0)  begin n_fail++; $display("FAIL reset_fault: got %b, expected 0", fault_a); end
    n_checks++; if (busy_a !== 1'b0)   begin n_fail++; $display("FAIL reset_busy_idle: got %b, expected 0", busy_a); end
    n_checks++; if (done_b !== 1'b0)   begin n_fail++; $display("FAIL reset_done_b: got %b, expected 0", done_b); end
    req_a = 1'b1; #1;
    n_checks++; if (busy_a !== 1'b1)   begin n_fail++; $display("FAIL reset_busy_req: got %b, expected 1", busy_a); end
    req_a = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_store_load;
    req_t tbl[$];
    exp_t e;
    obs_t o;
    tbl.push_back('{ST, 3'd2, 32'h10, 32'hDEADBEEF, 32'h0,        1'b0});
    tbl.push_back('{LD, 3'd2, 32'h10, 32'h0,        32'hDEADBEEF, 1'b0});
    tbl.push_back('{ST, 3'd0, 32'h11, 32'h00000011, 32'h0,        1'b0});
    tbl.push_back('{LD, 3'd2, 32'h10, 32'h0,        32'hDEAD11EF, 1'b0});
    tbl.push_back('{LD, 3'd4, 32'h13, 32'h0,        32'h000000DE, 1'b0});
    tbl.push_back('{LD, 3'd5, 32'h12, 32'h0,        32'h0000DEAD, 1'b0});
    tbl.push_back('{LD, 3'd0, 32'h10, 32'h0,        32'h000000EF, 1'b0});
    tbl.push_back('{LD, 3'd1, 32'h10, 32'h0,        32'h000011EF, 1'b0});
    tbl.push_back('{ST, 3'd1, 32'h12, 32'h1234ABCD, 32'h0,        1'b0});
    tbl.push_back('{LD, 3'd2, 32'h10, 32'h0,        32'hABCD11EF, 1'b0});
    foreach (tbl[i]) begin
      exp_q.push_back(expect_of(tbl[i], WS_A));
      run_req(tbl[i]);
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_checks++; if (o.rdata !== e.rdata) begin n_fail++; $display("FAIL store_load[%0d] rdata: got %h, expected %h", i, o.rdata, e.rdata); end
      n_checks++; if (o.fault !== e.fault) begin n_fail++; $display("FAIL store_load[%0d] fault: got %b, expected %b", i, o.fault, e.fault); end
      n_checks++; if (o.lat !== e.lat)     begin n_fail++; $display("FAIL store_load[%0d] latency: got %0d, expected %0d", i, o.lat, e.lat); end
      n_checks++; if (o.busy_gap || o.busy_resp) begin n_fail++; $display("FAIL store_load[%0d] busy: gap %b resp %b, expected 0 0", i, o.busy_gap, o.busy_resp); end
    end
  endtask

  task automatic test_faults;
    req_t tbl[$];
    exp_t e;
    obs_t o;
    tbl.push_back('{LD, 3'd1, 32'h11, 32'h0,        32'h0,        1'b1});
    tbl.push_back('{LD, 3'd2, 32'h10, 32'h0,        32'hABCD11EF, 1'b0});
    tbl.push_back('{LD, 3'd3, 32'h10, 32'h0,        32'h0,        1'b1});
    tbl.push_back('{ST, 3'd4, 32'h10, 32'hFFFFFFFF, 32'h0,        1'b1});
    tbl.push_back('{LD, 3'd2, 32'h10, 32'h0,        32'hABCD11EF, 1'b0});
    tbl.push_back('{LD, 3'd2, 32'h12, 32'h0,        32'h0,        1'b1});
    tbl.push_back('{ST, 3'd1, 32'h13, 32'hFFFFFFFF, 32'h0,        1'b1});
    tbl.push_back('{ST, 3'd2, 32'h11, 32'hFFFFFFFF, 32'h0,        1'b1});
    tbl.push_back('{LD, 3'd7, 32'h10, 32'h0,        32'h0,        1'b1});
    tbl.push_back('{LD, 3'd5, 32'h11, 32'h0,        32'h0,        1'b1});
    tbl.push_back('{LD, 3'd4, 32'h11, 32'h0,        32'h00000011, 1'b0});
    tbl.push_back('{LD, 3'd2, 32'h10, 32'h0,        32'hABCD11EF, 1'b0});
    foreach (tbl[i]) begin
      exp_q.push_back(expect_of(tbl[i], WS_A));
      run_req(tbl[i]);
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_checks++; if (o.rdata !== e.rdata) begin n_fail++; $display("FAIL faults[%0d] rdata: got %h, expected %h", i, o.rdata, e.rdata); end
      n_checks++; if (o.fault !== e.fault) begin n_fail++; $display("FAIL faults[%0d] fault: got %b, expected %b", i, o.fault, e.fault); end
      n_checks++; if (o.lat !== e.lat)     begin n_fail++; $display("FAIL faults[%0d] latency: got %0d, expected %0d", i, o.lat, e.lat); end
      n_checks++; if (o.busy_gap || o.busy_resp) begin n_fail++; $display("FAIL faults[%0d] busy: gap %b resp %b, expected 0 0", i, o.busy_gap, o.busy_resp); end
    end
  endtask

  task automatic test_reset_mid;
    exp_t e;
    obs_t o;
    run_req('{ST, 3'd2, 32'h20, 32'h55AA55AA, 32'h0, 1'b0});
    void'(obs_q.pop_front());
    exp_q.push_back('{32'h55AA55AA, 1'b0, WS_A + 2});
    run_req('{LD, 3'd2, 32'h20, 32'h0, 32'h55AA55AA, 1'b0});
    e = exp_q.pop_front(); o = obs_q.pop_front();
    n_checks++; if (o.rdata !== e.rdata) begin n_fail++; $display("FAIL reset_mid_pre rdata: got %h, expected %h", o.rdata, e.rdata); end
    op_a = ST; f3_a = 3'd2; addr_a = 32'h20; wdata_a = 32'h12345678; req_a = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_checks++; if (busy_a !== 1'b1) begin n_fail++; $display("FAIL reset_mid_wait busy: got %b, expected 1", busy_a); end
    rst_n = 1'b0;
    req_a = 1'b0; #1;
    n_checks++; if (busy_a !== 1'b0)      begin n_fail++; $display("FAIL reset_mid busy: got %b, expected 0", busy_a); end
    n_checks++; if (rdata_a !== 32'h0)    begin n_fail++; $display("FAIL reset_mid rdata: got %h, expected 0", rdata_a); end
    n_checks++; if (done_a !== 1'b0)      begin n_fail++; $display("FAIL reset_mid done: got %b, expected 0", done_a); end
    n_checks++; if (fault_a !== 1'b0)     begin n_fail++; $display("FAIL reset_mid fault: got %b, expected 0", fault_a); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    exp_q.push_back('{32'h55AA55AA, 1'b0, WS_A + 2});
    run_req('{LD, 3'd2, 32'h20, 32'h0, 32'h55AA55AA, 1'b0});
    e = exp_q.pop_front(); o = obs_q.pop_front();
    n_checks++; if (o.rdata !== e.rdata) begin n_fail++; $display("FAIL reset_mid_post rdata: got %h, expected %h", o.rdata, e.rdata); end
    n_checks++; if (o.lat !== e.lat)     begin n_fail++; $display("FAIL reset_mid_post latency: got %0d, expected %0d", o.lat, e.lat); end
  endtask

  task automatic test_wrap;
    req_t tbl[$];
    exp_t e;
    obs_t o;
    tbl.push_back('{ST, 3'd2, DEPTH * 4 + 32'h20, 32'h0BADF00D, 32'h0,        1'b0});
    tbl.push_back('{LD, 3'd2, 32'h20,             32'h0,        32'h0BADF00D, 1'b0});
    tbl.push_back('{LD, 3'd2, 32'hFFFFF020,       32'h0,        32'h0BADF00D, 1'b0});
    foreach (tbl[i]) begin
      exp_q.push_back(expect_of(tbl[i], WS_A));
      run_req(tbl[i]);
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_checks++; if (o.rdata !== e.rdata) begin n_fail++; $display("FAIL wrap[%0d] rdata: got %h, expected %h", i, o.rdata, e.rdata); end
      n_checks++; if (o.lat !== e.lat)     begin n_fail++; $display("FAIL wrap[%0d] latency: got %0d, expected %0d", i, o.lat, e.lat); end
    end
  endtask

  // Requests are re-presented during RESP, so each is accepted in the very next IDLE cycle.
  task automatic test_back_to_back;
    req_t        tbl[$];
    exp_t        e;
    int unsigned got;
    tbl.push_back('{ST, 3'd2, 32'h40, 32'hA5A5A5A5, 32'h0,        1'b0});
    tbl.push_back('{LD, 3'd2, 32'h40, 32'h0,        32'hA5A5A5A5, 1'b0});
    tbl.push_back('{ST, 3'd2, 32'h44, 32'h01020304, 32'h0,        1'b0});
    tbl.push_back('{LD, 3'd2, 32'h44, 32'h0,        32'h01020304, 1'b0});
    got = 0;
    op_b = tbl[0].op; f3_b = tbl[0].f3; addr_b = tbl[0].addr; wdata_b = tbl[0].wdata; req_b = 1'b1;
    exp_q.push_back('{tbl[0].rdata, 1'b0, 2});
    for (int unsigned c = 0; c < 60 && got < 4; c++) begin
      @(negedge clk);
      if (done_b && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_checks++; if (rdata_b !== e.rdata) begin n_fail++; $display("FAIL b2b[%0d] rdata: got %h, expected %h", got, rdata_b, e.rdata); end
        n_checks++; if (c !== e.lat)         begin n_fail++; $display("FAIL b2b[%0d] done_cycle: got %0d, expected %0d", got, c, e.lat); end
        n_checks++; if (fault_b !== 1'b0)    begin n_fail++; $display("FAIL b2b[%0d] fault: got %b, expected 0", got, fault_b); end
        got++;
        if (got < 4) begin
          op_b = tbl[got].op; f3_b = tbl[got].f3; addr_b = tbl[got].addr; wdata_b = tbl[got].wdata;
          exp_q.push_back('{tbl[got].rdata, 1'b0, 3 * got + 2});
        end else begin
          req_b = 1'b0;
        end
      end
    end
    req_b = 1'b0;
    n_checks++; if (got !== 4) begin n_fail++; $display("FAIL b2b completions: got %0d, expected 4", got); end
    exp_q.delete();
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_faults();
    test_reset_mid();
    test_wrap();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
